// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and loads the IF/ID
// pipeline register, applying branch/stall/jump priority and flagging out-of-ROM fetches.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INST  = 32'h0000_0000,
   parameter int unsigned ROM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_inst,
   output logic [31:0] pc,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        fetch_fault
);

   localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 32'd4);

   typedef enum logic [2:0] {
      SEL_SEQ    = 3'd0,
      SEL_BRANCH = 3'd1,
      SEL_STALL  = 3'd2,
      SEL_JUMP   = 3'd3,
      SEL_FAULT  = 3'd4
   } fetch_sel_t;

   fetch_sel_t  sel_s;
   logic [31:0] pc_r;
   logic [31:0] pc_plus4_s;
   logic        in_rom_s;
   logic [31:0] if_id_inst_r;
   logic [31:0] if_id_pc_r;
   logic [31:0] if_id_pc4_r;
   logic        if_id_valid_r;
   logic        fault_r;

   logic [31:0] pc_next_s;
   logic [31:0] inst_next_s;
   logic [31:0] ipc_next_s;
   logic [31:0] ipc4_next_s;
   logic        valid_next_s;
   logic        fault_next_s;

   assign pc_plus4_s = pc_r + 32'd4;
   assign in_rom_s   = (pc_r < ROM_BYTES);

   assign rom_addr    = pc_r;
   assign pc          = pc_r;
   assign if_id_inst  = if_id_inst_r;
   assign if_id_pc    = if_id_pc_r;
   assign if_id_pc4   = if_id_pc4_r;
   assign if_id_valid = if_id_valid_r;
   assign fetch_fault = fault_r;

   // Pick the action for this edge: EX branch beats the hazard stall, which beats an ID jump
   always_comb begin
      sel_s = SEL_SEQ;
      if (branch_taken) begin
         sel_s = SEL_BRANCH;
      end else if (stall) begin
         sel_s = SEL_STALL;
      end else if (jump) begin
         sel_s = SEL_JUMP;
      end else if (!in_rom_s) begin
         sel_s = SEL_FAULT;
      end else begin
         sel_s = SEL_SEQ;
      end
   end

   // Next PC and IF/ID contents; bubbles still record pc/pc+4 for debug visibility
   always_comb begin
      pc_next_s    = pc_r;
      inst_next_s  = if_id_inst_r;
      ipc_next_s   = if_id_pc_r;
      ipc4_next_s  = if_id_pc4_r;
      valid_next_s = if_id_valid_r;
      fault_next_s = fault_r;
      case (sel_s)
         SEL_BRANCH: begin
            pc_next_s    = {branch_target[31:2], 2'b00};
            inst_next_s  = NOP_INST;
            ipc_next_s   = pc_r;
            ipc4_next_s  = pc_plus4_s;
            valid_next_s = 1'b0;
         end
         SEL_STALL: begin
            pc_next_s = pc_r;
         end
         SEL_JUMP: begin
            pc_next_s    = {jump_target[31:2], 2'b00};
            inst_next_s  = NOP_INST;
            ipc_next_s   = pc_r;
            ipc4_next_s  = pc_plus4_s;
            valid_next_s = 1'b0;
         end
         SEL_FAULT: begin
            pc_next_s    = pc_plus4_s;
            inst_next_s  = NOP_INST;
            ipc_next_s   = pc_r;
            ipc4_next_s  = pc_plus4_s;
            valid_next_s = 1'b0;
            fault_next_s = 1'b1;
         end
         SEL_SEQ: begin
            pc_next_s    = pc_plus4_s;
            inst_next_s  = rom_inst;
            ipc_next_s   = pc_r;
            ipc4_next_s  = pc_plus4_s;
            valid_next_s = 1'b1;
         end
         default: begin
            pc_next_s    = pc_r;
            inst_next_s  = NOP_INST;
            ipc_next_s   = pc_r;
            ipc4_next_s  = pc_plus4_s;
            valid_next_s = 1'b0;
         end
      endcase
   end

   // PC, IF/ID register set and sticky fault flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r          <= RESET_PC;
         if_id_inst_r  <= NOP_INST;
         if_id_pc_r    <= 32'h0000_0000;
         if_id_pc4_r   <= 32'h0000_0000;
         if_id_valid_r <= 1'b0;
         fault_r       <= 1'b0;
      end else begin
         pc_r          <= pc_next_s;
         if_id_inst_r  <= inst_next_s;
         if_id_pc_r    <= ipc_next_s;
         if_id_pc4_r   <= ipc4_next_s;
         if_id_valid_r <= valid_next_s;
         fault_r       <= fault_next_s;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random redirects, checked against a
// behavioural fetch model; the bench ROM returns 32'hA000_0000 | address.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic [31:0] pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc, m_inst, m_ipc, m_ipc4;
   logic        m_valid, m_fault;

   if_stage #(.RESET_PC(32'h0), .NOP_INST(32'h0), .ROM_WORDS(64)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
      .rom_addr(rom_addr), .rom_inst(rom_inst), .pc(pc), .if_id_inst(if_id_inst),
      .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
      .fetch_fault(fetch_fault)
   );

   assign rom_inst = 32'hA000_0000 | rom_addr;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0;
   endtask

   // One clock of the fetch rules, using the inputs present at the edge
   task automatic model_edge();
      logic [31:0] old_pc;
      old_pc = m_pc;
      if (branch_taken || (!stall && jump) || (!stall && m_pc >= 32'd256)) begin
         m_inst = 32'h0; m_valid = 1'b0; m_ipc = old_pc; m_ipc4 = old_pc + 32'd4;
      end else if (!stall) begin
         m_inst = 32'hA000_0000 | old_pc; m_valid = 1'b1;
         m_ipc = old_pc; m_ipc4 = old_pc + 32'd4;
      end
      if (branch_taken)    m_pc = branch_target & 32'hFFFF_FFFC;
      else if (stall)      m_pc = m_pc;
      else if (jump)       m_pc = jump_target & 32'hFFFF_FFFC;
      else begin
         if (m_pc >= 32'd256) m_fault = 1'b1;
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, ".pc"},    pc, m_pc);
      chk({tag, ".rom"},   rom_addr, m_pc);
      chk({tag, ".inst"},  if_id_inst, m_inst);
      chk({tag, ".ipc"},   if_id_pc, m_ipc);
      chk({tag, ".ipc4"},  if_id_pc4, m_ipc4);
      chk({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
      chk({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      cmp_all(tag);
   endtask

   task automatic clear_inputs();
      stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      #1;
      model_reset();
      cmp_all("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset();

      // free run
      step("run1");
      chk("c1_ipc", if_id_pc, 32'h0);
      chk("c1_inst", if_id_inst, 32'hA000_0000);
      chk("c1_valid", 32'(if_id_valid), 32'd1);
      step("run2");
      step("run3");
      chk("c3_ipc", if_id_pc, 32'h8);
      chk("c3_ipc4", if_id_pc4, 32'hC);
      step("run4");
      chk("pre_stall_pc", pc, 32'h10);

      // stall two cycles
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step("stall");
         chk("stall_pc", pc, 32'h10);
         chk("stall_ipc", if_id_pc, 32'hC);
      end
      stall = 1'b0;
      step("unstall");
      chk("unstall_ipc", if_id_pc, 32'h10);
      chk("unstall_inst", if_id_inst, 32'hA000_0010);

      // jump from pc 0x08
      do_reset();
      step("j0");
      step("j1");
      chk("jump_from", pc, 32'h8);
      jump = 1'b1; jump_target = 32'h2E;
      step("jump");
      chk("jump_pc", pc, 32'h2C);
      chk("jump_valid", 32'(if_id_valid), 32'd0);
      chk("jump_inst", if_id_inst, 32'h0);
      jump = 1'b0;
      step("jump_next");
      chk("jump_ipc", if_id_pc, 32'h2C);
      chk("jump_nvalid", 32'(if_id_valid), 32'd1);

      // branch beats stall and jump
      branch_taken = 1'b1; branch_target = 32'h40;
      stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
      step("br");
      chk("br_pc", pc, 32'h40);
      chk("br_valid", 32'(if_id_valid), 32'd0);
      clear_inputs();
      step("br_next");
      chk("br_ipc", if_id_pc, 32'h40);

      // run off the end of the ROM
      branch_taken = 1'b1; branch_target = 32'hF8;
      step("to_end");
      clear_inputs();
      step("cap_f8");
      step("cap_fc");
      chk("fc_ipc", if_id_pc, 32'hFC);
      chk("fc_valid", 32'(if_id_valid), 32'd1);
      step("cap_100");
      chk("oob_valid", 32'(if_id_valid), 32'd0);
      chk("oob_fault", 32'(fetch_fault), 32'd1);
      branch_taken = 1'b1; branch_target = 32'h0;
      step("back0");
      clear_inputs();
      step("after_back");
      chk("fault_sticky", 32'(fetch_fault), 32'd1);
      do_reset();
      chk("fault_clr", 32'(fetch_fault), 32'd0);
      chk("rst_pc", pc, 32'h0);

      // PC wrap with low target bits cleared
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
      step("wrap_br");
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      clear_inputs();
      step("wrap");
      chk("wrap_zero", pc, 32'h0);

      // async reset in the middle of a branch cycle
      do_reset();
      step("a0");
      step("a1");
      branch_taken = 1'b1; branch_target = 32'h80;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      cmp_all("async_rst");
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;

      // random redirects, stalls and out-of-range targets
      for (int i = 0; i < 400; i++) begin
         stall        = ($urandom_range(0, 3) == 0);
         jump         = ($urandom_range(0, 5) == 0);
         branch_taken = ($urandom_range(0, 7) == 0);
         branch_target = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h13F));
         jump_target   = 32'($urandom_range(0, 32'h13F));
         step("rnd");
      end
      clear_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core. It holds the program counter and drives the instruction ROM address. It captures the combinational ROM output into the IF/ID pipeline register together with PC and PC+4. It handles load-use stalls, jump redirects from ID, and taken-branch redirects from EX, and flags fetches outside the ROM range.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, instruction word injected on flush/bubble.
ROM_WORDS, 64, number of 32-bit words in the instruction ROM; valid byte range is 0 .. ROM_WORDS*4-1.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hazard unit: hold PC and IF/ID.
branch_taken  in  1  EX stage: branch resolved taken.
branch_target  in  32  EX stage: branch destination byte address.
jump  in  1  ID stage: jump decoded.
jump_target  in  32  ID stage: jump destination byte address.
rom_addr  out  32  byte address to instruction ROM; equals pc.
rom_inst  in  32  combinational instruction word from ROM.
pc  out  32  current fetch PC.
if_id_inst  out  32  IF/ID instruction.
if_id_pc  out  32  IF/ID address of that instruction.
if_id_pc4  out  32  IF/ID address + 4.
if_id_valid  out  1  IF/ID holds a real instruction.
fetch_fault  out  1  sticky: a fetch was attempted outside the ROM range.

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_PC; if_id_inst=NOP_INST; if_id_pc=0; if_id_pc4=0; if_id_valid=0; fetch_fault=0. The first valid fetch is captured on the first rising edge after rst deasserts.
- rom_addr = pc, combinational. The instruction for pc is available in the same cycle and is registered into IF/ID at the next edge. IF-to-ID latency is 1 cycle.
- PC update, priority high to low, evaluated each rising edge:
  1. branch_taken: pc <= {branch_target[31:2],2'b00}. Overrides stall and jump.
  2. stall: pc holds.
  3. jump: pc <= {jump_target[31:2],2'b00}.
  4. Otherwise: pc <= pc+4, modulo 2^32 (wraps 32'hFFFF_FFFC to 0).
- IF/ID update at the same edge:
  - branch_taken: load bubble (if_id_inst=NOP_INST, if_id_valid=0). This discards the wrong-path fetch. ID/EX flushing is outside this block.
  - else stall: all IF/ID fields hold.
  - else jump: load bubble. No delay slot; the sequential fetch is discarded.
  - else, with pc < ROM_WORDS*4: if_id_inst=rom_inst, if_id_pc=pc, if_id_pc4=pc+4, if_id_valid=1.
  - else, with pc >= ROM_WORDS*4: load bubble and set fetch_fault=1. PC still advances.
- fetch_fault:
  - Sticky until rst.
  - Only set on a non-stalled, non-redirected capture cycle.
- Target bits [1:0] are silently cleared. No misalignment fault.
- stall and jump together: jump is ignored that cycle. The ID stage re-presents the jump when stall drops.
- Bubble fields: if_id_pc and if_id_pc4 are loaded with the current pc and pc+4 (debug only).
- State: the PC register, the IF/ID register set, and the sticky fault bit. Sequential logic only; no combinational path from inputs to registered outputs.

Test Plan:
- Reset then free-run, bench ROM returning 32'hA000_0000|addr:
  - Cycle 1 after reset: if_id_pc=0, if_id_inst=32'hA000_0000, valid=1.
  - Cycle 3: if_id_pc=8, if_id_pc4=12.
- stall high 2 cycles while pc=0x10: pc stays 0x10 and IF/ID stays at pc 0x0C for both cycles. On release, IF/ID captures pc 0x10 inst 32'hA000_0010.
- jump=1, jump_target=0x2E (pc=0x08):
  - Next edge: pc=0x2C, IF/ID bubble (valid=0, inst=0).
  - Following edge: IF/ID pc=0x2C, valid=1.
- branch_taken=1, target 0x40, with stall=1 and jump=1 in the same cycle: pc=0x40 and IF/ID bubble (branch wins). The next capture has if_id_pc=0x40.
- Run past the ROM with ROM_WORDS=64:
  - Capture at pc=0xFC is valid.
  - At pc=0x100: valid=0 and fetch_fault=1, which stays 1 after a branch back to 0.
  - Asserting rst clears fetch_fault and returns pc to 0.
- Assert rst asynchronously mid-cycle during a branch_taken: pc=RESET_PC and all outputs take reset values immediately, without waiting for a clock edge.
